// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants the single SDRAM command/data port to one of three cache
// refill requesters (program fill, data fill, dirty writeback) per line burst.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   pf_/df_/wb_req, *_addr         requests (held until done) and line addresses
//   pf_/df_/wb_done                one-cycle completion pulse to the finished owner
//   pf_valid, df_valid, fill_data  read beats routed to the owning fill port
//   wb_data, wb_next               writeback word in, consumed-word strobe out
//   mem_cmd_*                      burst command handshake to the SDRAM controller
//   mem_wdata, mem_wnext           write beat data out, controller beat strobe in
//   mem_rdata, mem_rvalid          read beat data and strobe from the controller
//   grant, busy                    current owner (00 none, 01 pf, 10 df, 11 wb), not-idle
//
// Optional feature: define ARB_ROUND_ROBIN_EN for rotating priority
// (wb still beats df); otherwise fixed wb > df > pf.
module sdram_arbiter #(
   parameter int ADDR_W    = 24,
   parameter int BURST_LEN = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pf_req,
   input  logic              df_req,
   input  logic              wb_req,
   input  logic [ADDR_W-1:0] pf_addr,
   input  logic [ADDR_W-1:0] df_addr,
   input  logic [ADDR_W-1:0] wb_addr,
   output logic              pf_done,
   output logic              df_done,
   output logic              wb_done,
   output logic              pf_valid,
   output logic              df_valid,
   output logic [15:0]       fill_data,
   input  logic [15:0]       wb_data,
   output logic              wb_next,
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic              mem_cmd_write,
   output logic [ADDR_W-1:0] mem_cmd_addr,
   output logic [15:0]       mem_wdata,
   input  logic              mem_wnext,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_rvalid,
   output logic [1:0]        grant,
   output logic              busy
);
   localparam int LW = $clog2(BURST_LEN);
   localparam int CW = LW + 1;

   typedef enum logic [1:0] {IDLE, CMD, XFER, DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        grant_q, grant_d, mask_q, mask_d, win;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              pf_r, df_r, wb_r, rd, wr, beat;
   logic [ADDR_W-1:0] own_addr;

   // The port that just finished still shows its request for one cycle after done.
   assign pf_r = pf_req & (mask_q != 2'b01);
   assign df_r = df_req & (mask_q != 2'b10);
   assign wb_r = wb_req & (mask_q != 2'b11);

`ifdef ARB_ROUND_ROBIN_EN
   logic [1:0] last_q;
   logic       df_e;
   // Rotation puts the last winner lowest; df is hidden whenever wb is pending
   // so a dirty victim is always written before its replacement is read.
   always_comb begin
      df_e = df_r & ~wb_r;
      case (last_q)
         2'b01:   win = df_e ? 2'b10 : wb_r ? 2'b11 : pf_r ? 2'b01 : 2'b00;
         2'b10:   win = wb_r ? 2'b11 : pf_r ? 2'b01 : df_e ? 2'b10 : 2'b00;
         default: win = pf_r ? 2'b01 : df_e ? 2'b10 : wb_r ? 2'b11 : 2'b00;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         last_q <= 2'b11;
      else if (state_q == IDLE && win != 2'b00)
         last_q <= win;
`else
   assign win = wb_r ? 2'b11 : df_r ? 2'b10 : pf_r ? 2'b01 : 2'b00;
`endif

   assign own_addr = grant_q == 2'b11 ? wb_addr : grant_q == 2'b10 ? df_addr : pf_addr;
   assign rd       = state_q == XFER && grant_q != 2'b11;
   assign wr       = state_q == XFER && grant_q == 2'b11;
   assign beat     = (rd & mem_rvalid) | (wr & mem_wnext);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      mask_d  = 2'b00;
      case (state_q)
         IDLE: if (win != 2'b00) begin
            state_d = CMD;
            grant_d = win;
         end
         CMD: if (mem_cmd_ready) begin
            state_d = XFER;
            cnt_d   = '0;
         end
         XFER: if (beat) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(BURST_LEN - 1))
               state_d = DONE;
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
            mask_d  = grant_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= 2'b00;
         cnt_q   <= '0;
         mask_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
      end

   assign busy          = state_q != IDLE;
   assign grant         = grant_q;
   assign mem_cmd_valid = state_q == CMD;
   assign mem_cmd_write = state_q == CMD && grant_q == 2'b11;
   assign mem_cmd_addr  = state_q == CMD ? {own_addr[ADDR_W-1:LW], {LW{1'b0}}} : '0;
   assign fill_data     = rd ? mem_rdata : 16'h0;
   assign pf_valid      = rd & mem_rvalid & (grant_q == 2'b01);
   assign df_valid      = rd & mem_rvalid & (grant_q == 2'b10);
   assign mem_wdata     = wr ? wb_data : 16'h0;
   assign wb_next       = wr & mem_wnext;
   assign pf_done       = state_q == DONE && grant_q == 2'b01;
   assign df_done       = state_q == DONE && grant_q == 2'b10;
   assign wb_done       = state_q == DONE && grant_q == 2'b11;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench for sdram_arbiter with directed bursts.
module tb_sdram_arbiter;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic        pf_req = 0, df_req = 0, wb_req = 0;
   logic [23:0] pf_addr = 0, df_addr = 0, wb_addr = 0;
   logic        pf_done, df_done, wb_done, pf_valid, df_valid, wb_next;
   logic [15:0] fill_data, mem_wdata;
   logic [15:0] wb_data = 0, mem_rdata = 0;
   logic        mem_cmd_valid, mem_cmd_write, busy;
   logic        mem_cmd_ready = 0, mem_wnext = 0, mem_rvalid = 0;
   logic [23:0] mem_cmd_addr;
   logic [1:0]  grant;

   typedef struct packed {logic w; logic [23:0] a; logic [1:0] g;} cmd_t;
   cmd_t        exp_cmd[$];
   logic [17:0] exp_fill[$];
   logic [15:0] exp_wb[$];
   logic [2:0]  exp_done[$];
   int          tests = 0, fails = 0;
   logic [1:0]  p1, p2;

   always #5 clk = ~clk;

   sdram_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .pf_req(pf_req), .df_req(df_req), .wb_req(wb_req),
      .pf_addr(pf_addr), .df_addr(df_addr), .wb_addr(wb_addr),
      .pf_done(pf_done), .df_done(df_done), .wb_done(wb_done),
      .pf_valid(pf_valid), .df_valid(df_valid), .fill_data(fill_data),
      .wb_data(wb_data), .wb_next(wb_next),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
      .mem_wdata(mem_wdata), .mem_wnext(mem_wnext),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .grant(grant), .busy(busy)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] all_out();
      return {pf_done, df_done, wb_done, pf_valid, df_valid, fill_data, wb_next,
              mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_wdata, grant, busy};
   endfunction

   function automatic logic [2:0] dvec(input logic [1:0] p);
      return p == 2'b11 ? 3'b100 : p == 2'b10 ? 3'b010 : 3'b001;
   endfunction

   // Monitor: compares every DUT presentation against the head of its queue.
   always @(negedge clk) begin
      if (mem_cmd_valid) begin
         if (exp_cmd.size() == 0) chk("cmd_unexpected", mem_cmd_valid, 1'b0);
         else begin
            chk("cmd", {mem_cmd_write, mem_cmd_addr, grant}, exp_cmd[0]);
            if (mem_cmd_ready) void'(exp_cmd.pop_front());
         end
      end
      if (pf_valid | df_valid) begin
         if (exp_fill.size() == 0) chk("fill_unexpected", {df_valid, pf_valid}, 2'b00);
         else chk("fill", {df_valid, pf_valid, fill_data}, exp_fill.pop_front());
      end
      if (wb_next) begin
         if (exp_wb.size() == 0) chk("wb_next_unexpected", wb_next, 1'b0);
         else chk("wb_data", mem_wdata, exp_wb.pop_front());
      end
      if (pf_done | df_done | wb_done) begin
         if (exp_done.size() == 0) chk("done_unexpected", {wb_done, df_done, pf_done}, 3'b000);
         else chk("done", {wb_done, df_done, pf_done}, exp_done.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cmd(input string name);
      int n = 0;
      while (!(mem_cmd_valid && mem_cmd_ready) && n < 50) begin
         step();
         n++;
      end
      chk({name, "_cmd_timeout"}, n < 50, 1'b1);
      step();
   endtask

   task automatic read_beats(input logic [1:0] p, input logic [15:0] base);
      for (int i = 0; i < 8; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = base + 16'(i);
         mem_wnext  = i[0];
         exp_fill.push_back({p, base + 16'(i)});
         step();
         if (i == 2 || i == 5) begin
            mem_rvalid = 1'b0;
            mem_wnext  = 1'b0;
            step();
         end
      end
      mem_rvalid = 1'b0;
      mem_wnext  = 1'b0;
   endtask

   task automatic write_beats(input logic [15:0] base);
      for (int i = 0; i < 8; i++) begin
         wb_data    = base + 16'(i);
         mem_wnext  = 1'b1;
         mem_rvalid = ~i[0];
         mem_rdata  = 16'hDEAD;
         exp_wb.push_back(base + 16'(i));
         step();
         if (i == 3) begin
            mem_wnext  = 1'b0;
            mem_rvalid = 1'b1;
            step();
         end
      end
      mem_wnext  = 1'b0;
      mem_rvalid = 1'b0;
   endtask

   // Called in the DONE cycle; the requester keeps its request through the
   // following IDLE cycle and drops it afterwards.
   task automatic finish(input logic [1:0] p);
      chk("done_now", {wb_done, df_done, pf_done}, dvec(p));
      step();
      chk("idle_after_done", {busy, grant}, 3'b000);
      step();
      if (p == 2'b01) pf_req = 1'b0;
      else if (p == 2'b10) df_req = 1'b0;
      else wb_req = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_outputs", all_out(), '0);
      step();
      reset_n       = 1'b1;
      mem_cmd_ready = 1'b1;

      // Spurious beats while idle
      mem_rvalid = 1'b1;
      mem_wnext  = 1'b1;
      mem_rdata  = 16'h1111;
      repeat (3) step();
      chk("idle_spurious", {pf_valid, df_valid, wb_next, busy}, 4'b0000);
      mem_rvalid = 1'b0;
      mem_wnext  = 1'b0;

      // Single program fill
      exp_cmd.push_back(cmd_t'({1'b0, 24'h012340, 2'b01}));
      exp_done.push_back(3'b001);
      pf_addr = 24'h012345;
      pf_req  = 1'b1;
      step();
      chk("req_to_cmd_latency", mem_cmd_valid, 1'b1);
      wait_cmd("pf");
      read_beats(2'b01, 16'hA000);
      finish(2'b01);

      // Writeback and data fill together: writeback first
      exp_cmd.push_back(cmd_t'({1'b1, 24'h00ABC8, 2'b11}));
      exp_done.push_back(3'b100);
      exp_cmd.push_back(cmd_t'({1'b0, 24'h3F0000, 2'b10}));
      exp_done.push_back(3'b010);
      wb_addr = 24'h00ABCF;
      df_addr = 24'h3F0007;
      wb_req  = 1'b1;
      df_req  = 1'b1;
      step();
      wait_cmd("wb");
      write_beats(16'h5000);
      finish(2'b11);
      chk("df_cmd_two_after_done", {mem_cmd_valid, grant}, 3'b110);
      wait_cmd("df");
      read_beats(2'b10, 16'hB000);
      finish(2'b10);

      // Command stalled by the controller
      mem_cmd_ready = 1'b0;
      exp_cmd.push_back(cmd_t'({1'b0, 24'hABCDE8, 2'b01}));
      exp_done.push_back(3'b001);
      pf_addr = 24'hABCDEF;
      pf_req  = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("cmd_held", {mem_cmd_valid, busy}, 2'b11);
         step();
      end
      mem_cmd_ready = 1'b1;
      chk("cmd_held_ready", mem_cmd_valid, 1'b1);
      step();
      chk("xfer_after_ready", {mem_cmd_valid, busy}, 2'b01);
      read_beats(2'b01, 16'hC000);
      finish(2'b01);

      // Reset on the third beat of a data fill
      exp_cmd.push_back(cmd_t'({1'b0, 24'h000100, 2'b10}));
      df_addr = 24'h000103;
      df_req  = 1'b1;
      step();
      wait_cmd("df_abort");
      for (int i = 0; i < 2; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 16'hD000 + 16'(i);
         exp_fill.push_back({2'b10, 16'hD000 + 16'(i)});
         step();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 16'hD002;
      #2 reset_n = 1'b0;
      #1 chk("async_reset_outputs", all_out(), '0);
      df_req     = 1'b0;
      mem_rvalid = 1'b0;
      step();
      step();
      chk("reset_held_outputs", all_out(), '0);
      reset_n = 1'b1;
      exp_cmd.push_back(cmd_t'({1'b0, 24'h000100, 2'b10}));
      exp_done.push_back(3'b010);
      df_req = 1'b1;
      step();
      wait_cmd("df_fresh");
      read_beats(2'b10, 16'hE000);
      finish(2'b10);

      // Program and data fill pending together
`ifdef ARB_ROUND_ROBIN_EN
      p1 = 2'b01;
      p2 = 2'b10;
`else
      p1 = 2'b10;
      p2 = 2'b01;
`endif
      pf_addr = 24'h000009;
      df_addr = 24'h7654FF;
      exp_cmd.push_back(cmd_t'({1'b0, p1 == 2'b01 ? 24'h000008 : 24'h7654F8, p1}));
      exp_done.push_back(dvec(p1));
      exp_cmd.push_back(cmd_t'({1'b0, p2 == 2'b01 ? 24'h000008 : 24'h7654F8, p2}));
      exp_done.push_back(dvec(p2));
      pf_req = 1'b1;
      df_req = 1'b1;
      step();
      wait_cmd("first");
      read_beats(p1, 16'hF000);
      finish(p1);
      chk("second_grant", {mem_cmd_valid, grant}, {1'b1, p2});
      wait_cmd("second");
      read_beats(p2, 16'hF100);
      finish(p2);

      repeat (3) step();
      chk("cmd_queue_empty", exp_cmd.size(), 0);
      chk("fill_queue_empty", exp_fill.size(), 0);
      chk("wb_queue_empty", exp_wb.size(), 0);
      chk("done_queue_empty", exp_done.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
